// File: rtl/sp8k_fifo_ctrl.sv
// rtl/sp8k_fifo_ctrl.sv - FWFT FIFO controller sharing one SP8KA port between writes and prefetch reads
module sp8k_fifo_ctrl #(
    parameter int DATA_WIDTH   = 18,
    parameter int ADDR_WIDTH   = 9,
    parameter int READ_LATENCY = 1
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  WR_VALID,
    output logic                  WR_READY,
    input  logic [DATA_WIDTH-1:0] WR_DATA,
    output logic                  RD_VALID,
    input  logic                  RD_READY,
    output logic [DATA_WIDTH-1:0] RD_DATA,
    output logic [ADDR_WIDTH+1:0] COUNT,
    output logic                  RAM_CE,
    output logic                  RAM_WE,
    output logic [ADDR_WIDTH-1:0] RAM_AD,
    output logic [DATA_WIDTH-1:0] RAM_DI,
    input  logic [DATA_WIDTH-1:0] RAM_DO
);

    localparam int OB_DEPTH = READ_LATENCY + 2;
    localparam int OBC_W    = $clog2(OB_DEPTH + 1);
    localparam int CW       = ADDR_WIDTH + 2;
    localparam logic [CW-1:0] OB_LIMIT = CW'(OB_DEPTH);

    logic [ADDR_WIDTH-1:0]   wptr;
    logic [ADDR_WIDTH-1:0]   rptr;
    logic [ADDR_WIDTH:0]     mem_count;
    logic [READ_LATENCY-1:0] inflight;
    logic [DATA_WIDTH-1:0]   ob [OB_DEPTH];
    logic [OBC_W-1:0]        ob_count;
    logic                    last_rd;

    logic [CW-1:0]    inflight_cnt;
    logic [CW-1:0]    ob_level;
    logic             read_req;
    logic             wr_fire;
    logic             rd_grant;
    logic             push;
    logic             pop;
    logic [OBC_W-1:0] push_idx;

    always_comb begin
        inflight_cnt = '0;
        for (int i = 0; i < READ_LATENCY; i++)
            inflight_cnt = inflight_cnt + {{(CW-1){1'b0}}, inflight[i]};
    end

    assign ob_level = {{(CW-OBC_W){1'b0}}, ob_count};

    // Only prefetch when every outstanding read is guaranteed an OB slot on return
    assign read_req = (mem_count != '0) && ((ob_level + inflight_cnt) < OB_LIMIT);
    assign WR_READY = !RST && !mem_count[ADDR_WIDTH] && !(read_req && !last_rd);
    assign wr_fire  = WR_VALID && WR_READY;
    assign rd_grant = read_req && !wr_fire;

    assign RAM_CE = wr_fire | rd_grant;
    assign RAM_WE = wr_fire;
    assign RAM_AD = wr_fire ? wptr : rptr;
    assign RAM_DI = WR_DATA;

    assign push     = inflight[READ_LATENCY-1];
    assign pop      = RD_VALID && RD_READY;
    assign push_idx = ob_count - {{(OBC_W-1){1'b0}}, pop};

    assign RD_VALID = (ob_count != '0);
    assign RD_DATA  = ob[0];
    assign COUNT    = {1'b0, mem_count} + inflight_cnt + ob_level;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wptr      <= '0;
            rptr      <= '0;
            mem_count <= '0;
            inflight  <= '0;
            ob_count  <= '0;
            last_rd   <= 1'b0;
            for (int i = 0; i < OB_DEPTH; i++)
                ob[i] <= '0;
        end else begin
            if (wr_fire)
                wptr <= wptr + 1'b1;
            if (rd_grant)
                rptr <= rptr + 1'b1;
            case ({wr_fire, rd_grant})
                2'b10:   mem_count <= mem_count + 1'b1;
                2'b01:   mem_count <= mem_count - 1'b1;
                default: mem_count <= mem_count;
            endcase
            inflight[0] <= rd_grant;
            for (int i = 1; i < READ_LATENCY; i++)
                inflight[i] <= inflight[i-1];
            last_rd <= rd_grant;
            // Head shifts only over occupied slots so an emptied OB keeps its last word
            for (int i = 0; i < OB_DEPTH - 1; i++)
                if (pop && (OBC_W'(i + 1) < ob_count))
                    ob[i] <= ob[i+1];
            if (push)
                ob[push_idx] <= RAM_DO;
            ob_count <= ob_count + {{(OBC_W-1){1'b0}}, push} - {{(OBC_W-1){1'b0}}, pop};
        end
    end

endmodule
